// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - four-digit seven-segment scan controller with tear-free shadow update handshake
module display_scan_controller #(
    parameter int DIVIDE_BY = 100000
) (
    input  logic        clk,
    input  logic        btnC,
    input  logic [15:0] digits_in,
    input  logic [3:0]  blank_in,
    input  logic        update_req,
    output logic        update_ack,
    output logic [3:0]  an,
    output logic [3:0]  hex,
    output logic [1:0]  digit_idx,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ACK     = 2'd2
    } hsState_t;

    localparam logic [19:0] LAST_COUNT = 20'(DIVIDE_BY - 1);

    logic [19:0] prescaleCount;
    logic        tick;
    logic        frameBoundary;
    logic        loadShadow;
    logic [1:0]  nextIdx;
    logic [15:0] shadowDigits;
    logic [3:0]  shadowBlank;
    logic [15:0] frameDigits;
    logic [3:0]  frameBlank;
    hsState_t    state;
    hsState_t    nextState;

    assign tick          = (prescaleCount == LAST_COUNT);
    assign frameBoundary = tick && (digit_idx == 2'd3);
    assign nextIdx       = digit_idx + 2'd1;
    assign update_ack    = (state == ACK);

    // A load lands on the 3->0 edge, so the new frame's digit 0 must already see the incoming values
    assign frameDigits = loadShadow ? digits_in : shadowDigits;
    assign frameBlank  = loadShadow ? blank_in  : shadowBlank;

    // Prescaler: counts 0..DIVIDE_BY-1 and wraps, tick marks the last count
    always_ff @(posedge clk or posedge btnC) begin
        if (btnC) begin
            prescaleCount <= 20'd0;
        end else if (tick) begin
            prescaleCount <= 20'd0;
        end else begin
            prescaleCount <= prescaleCount + 20'd1;
        end
    end

    // Handshake state register
    always_ff @(posedge clk or posedge btnC) begin
        if (btnC) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Handshake next-state: a request only loads on a boundary seen while already pending
    always_comb begin
        nextState  = state;
        loadShadow = 1'b0;
        case (state)
            IDLE: begin
                if (update_req) begin
                    nextState = PENDING;
                end
            end
            PENDING: begin
                if (!update_req) begin
                    nextState = IDLE;
                end else if (frameBoundary) begin
                    nextState  = ACK;
                    loadShadow = 1'b1;
                end
            end
            ACK: begin
                if (!update_req) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Shadow registers change only on the load edge; reset leaves the display dark
    always_ff @(posedge clk or posedge btnC) begin
        if (btnC) begin
            shadowDigits <= 16'h0000;
            shadowBlank  <= 4'b1111;
        end else if (loadShadow) begin
            shadowDigits <= digits_in;
            shadowBlank  <= blank_in;
        end
    end

    // Scan outputs: index, anode and nibble move together so they always describe one digit
    always_ff @(posedge clk or posedge btnC) begin
        if (btnC) begin
            digit_idx <= 2'd0;
            an        <= 4'b1111;
            hex       <= 4'h0;
        end else if (tick) begin
            digit_idx <= nextIdx;
            an        <= frameBlank[nextIdx] ? 4'b1111 : ~(4'b0001 << nextIdx);
            hex       <= frameDigits[{nextIdx, 2'b00} +: 4];
        end
    end

    // Frame pulse: one cycle, in the cycle after the 3->0 wrap edge
    always_ff @(posedge clk or posedge btnC) begin
        if (btnC) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= frameBoundary;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - self-checking bench for display_scan_controller
`timescale 1ns/1ps
module tb_display_scan_controller;

    logic        clk = 1'b0;
    logic        btnC;
    logic [15:0] digitsIn;
    logic [3:0]  blankIn;
    logic        updateReq;
    logic        updateAck;
    logic [3:0]  an;
    logic [3:0]  hex;
    logic [1:0]  digitIdx;
    logic        frameDone;

    logic [15:0] digitsIn4 = 16'h0;
    logic [3:0]  blankIn4  = 4'h0;
    logic        updateReq4 = 1'b0;
    logic        updateAck4;
    logic [3:0]  an4;
    logic [3:0]  hex4;
    logic [1:0]  digitIdx4;
    logic        frameDone4;

    int asserts = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    display_scan_controller #(.DIVIDE_BY(1)) dut (
        .clk(clk), .btnC(btnC), .digits_in(digitsIn), .blank_in(blankIn),
        .update_req(updateReq), .update_ack(updateAck), .an(an), .hex(hex),
        .digit_idx(digitIdx), .frame_done(frameDone)
    );

    display_scan_controller #(.DIVIDE_BY(4)) dut4 (
        .clk(clk), .btnC(btnC), .digits_in(digitsIn4), .blank_in(blankIn4),
        .update_req(updateReq4), .update_ack(updateAck4), .an(an4), .hex(hex4),
        .digit_idx(digitIdx4), .frame_done(frameDone4)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] hex;
        logic [1:0] idx;
    } exp_t;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  blank;
        logic [15:0] expAn;   // nibble k = expected an while digit k active
        logic [15:0] expHex;  // nibble k = expected hex while digit k active
    } vec_t;

    exp_t sbQ[$];
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic popCompare(input string name);
        exp_t e;
        if (sbQ.size() == 0) begin
            check({name, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = sbQ.pop_front();
            check({name, "_an"},  32'(an),       32'(e.an));
            check({name, "_hex"}, 32'(hex),      32'(e.hex));
            check({name, "_idx"}, 32'(digitIdx), 32'(e.idx));
        end
    endtask

    task automatic waitAck(output int cycles);
        cycles = 0;
        while (!updateAck && cycles < 16) begin
            @(negedge clk);
            cycles++;
        end
        check("ack_within_bound", 32'(updateAck), 32'd1);
    endtask

    task automatic waitIdx(input logic [1:0] target);
        int n = 0;
        while (digitIdx != target && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("wait_idx", 32'(digitIdx == target), 32'd1);
    endtask

    // Loads one table vector, then checks eight scan cycles starting at digit 0 of the new frame
    task automatic runVec(input int v, output int cycles);
        exp_t e;
        digitsIn  = vecs[v].digits;
        blankIn   = vecs[v].blank;
        updateReq = 1'b1;
        waitAck(cycles);
        for (int k = 0; k < 8; k++) begin
            e.an  = vecs[v].expAn[4*(k%4) +: 4];
            e.hex = vecs[v].expHex[4*(k%4) +: 4];
            e.idx = 2'(k % 4);
            sbQ.push_back(e);
        end
        popCompare($sformatf("vec%0d_d0", v));
        updateReq = 1'b0;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            popCompare($sformatf("vec%0d_c%0d", v, k));
            if (k == 1) check($sformatf("vec%0d_ack_drop", v), 32'(updateAck), 32'd0);
        end
    endtask

    initial begin
        int cycles;
        int fdCount;
        exp_t e;

        vecs[0] = '{digits: 16'h4321, blank: 4'b0000, expAn: {4'b0111, 4'b1011, 4'b1101, 4'b1110}, expHex: 16'h4321};
        vecs[1] = '{digits: 16'hFFFF, blank: 4'b0000, expAn: {4'b0111, 4'b1011, 4'b1101, 4'b1110}, expHex: 16'hFFFF};
        vecs[2] = '{digits: 16'hABCD, blank: 4'b0101, expAn: {4'b0111, 4'b1111, 4'b1101, 4'b1111}, expHex: 16'hABCD};
        vecs[3] = '{digits: 16'h0F5A, blank: 4'b1010, expAn: {4'b1111, 4'b1011, 4'b1111, 4'b1110}, expHex: 16'h0F5A};
        vecs[4] = '{digits: 16'h1234, blank: 4'b1111, expAn: {4'b1111, 4'b1111, 4'b1111, 4'b1111}, expHex: 16'h1234};

        btnC = 1'b1; digitsIn = 16'h0; blankIn = 4'h0; updateReq = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_an",   32'(an),        32'hF);
        check("rst_hex",  32'(hex),       32'h0);
        check("rst_ack",  32'(updateAck), 32'h0);
        check("rst_fd",   32'(frameDone), 32'h0);
        check("rst_idx",  32'(digitIdx),  32'h0);
        btnC = 1'b0;

        // Prescaler of 4: index moves every 4 edges, frame pulse every 16; the unloaded display stays dark
        fdCount = 0;
        for (int n = 1; n <= 64; n++) begin
            @(negedge clk);
            check($sformatf("div4_idx_%0d", n), 32'(digitIdx4), 32'((n / 4) % 4));
            check($sformatf("div4_fd_%0d", n), 32'(frameDone4), 32'(n % 16 == 0));
            if (frameDone4) fdCount++;
            if (n % 8 == 0) check($sformatf("dark_an_%0d", n), 32'(an), 32'hF);
        end
        check("div4_fd_count", 32'(fdCount), 32'd4);

        // Fresh reset, request immediately: the first boundary is the fourth edge
        btnC = 1'b1;
        @(negedge clk);
        btnC = 1'b0;
        runVec(0, cycles);
        check("first_ack_latency", 32'(cycles), 32'd4);
        for (int v = 1; v < 5; v++) runVec(v, cycles);

        // Update requested while digit 1 is active: the current frame finishes with old values
        runVec(0, cycles);
        waitIdx(2'd1);
        digitsIn = 16'hFFFF; blankIn = 4'b0000; updateReq = 1'b1;
        sbQ.push_back('{an: 4'b1101, hex: 4'h2, idx: 2'd1});
        sbQ.push_back('{an: 4'b1011, hex: 4'h3, idx: 2'd2});
        sbQ.push_back('{an: 4'b0111, hex: 4'h4, idx: 2'd3});
        sbQ.push_back('{an: 4'b1110, hex: 4'hF, idx: 2'd0});
        popCompare("tear_d1");
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            popCompare($sformatf("tear_%0d", k));
        end
        check("tear_ack", 32'(updateAck), 32'd1);
        updateReq = 1'b0;
        @(negedge clk);

        // Request withdrawn while pending: no ack and the shadow contents stay FFFF
        waitIdx(2'd0);
        digitsIn = 16'h1111; blankIn = 4'b1111; updateReq = 1'b1;
        @(negedge clk);
        updateReq = 1'b0;
        for (int k = 0; k < 8; k++) begin
            e.idx = 2'((k + 2) % 4);
            e.an  = ~(4'b0001 << e.idx);
            e.hex = 4'hF;
            sbQ.push_back(e);
            @(negedge clk);
            popCompare($sformatf("abort_%0d", k));
            check($sformatf("abort_ack_%0d", k), 32'(updateAck), 32'd0);
        end

        // Reset during ACK drops ack and blanks the display without a clock edge
        digitsIn = 16'h4321; blankIn = 4'b0000; updateReq = 1'b1;
        waitAck(cycles);
        @(posedge clk);
        #2 btnC = 1'b1;
        #1;
        check("async_ack", 32'(updateAck), 32'd0);
        check("async_an",  32'(an),        32'hF);
        check("async_hex", 32'(hex),       32'h0);
        @(negedge clk);
        btnC = 1'b0; updateReq = 1'b0;
        repeat (6) @(negedge clk);
        check("post_rst_dark", 32'(an), 32'hF);
        check("post_rst_ack",  32'(updateAck), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
